// File: rtl/dhcp_vlg_pkg.sv
// Shared definitions for the DHCP receive path: well-known ports, option
// codes, the magic cookie, the parser state encoding, the bundle of parsed
// lease fields and a fixed-header byte checker.
package dhcp_vlg_pkg;

  localparam logic [31:0] DHCP_MAGIC_COOKIE = 32'h6382_5363;
  localparam logic [15:0] DHCP_SRV_PORT     = 16'd67;
  localparam logic [15:0] DHCP_CLI_PORT     = 16'd68;

  localparam logic [7:0] DHCP_OPT_PAD         = 8'd0;
  localparam logic [7:0] DHCP_OPT_SUBNET_MASK = 8'd1;
  localparam logic [7:0] DHCP_OPT_ROUTER      = 8'd3;
  localparam logic [7:0] DHCP_OPT_DNS         = 8'd6;
  localparam logic [7:0] DHCP_OPT_LEASE_TIME  = 8'd51;
  localparam logic [7:0] DHCP_OPT_MSG_TYPE    = 8'd53;
  localparam logic [7:0] DHCP_OPT_SRV_ID      = 8'd54;
  localparam logic [7:0] DHCP_OPT_END         = 8'd255;

  typedef enum logic [2:0] {
    IDLE, HDR, OPT_CODE, OPT_LEN, OPT_DAT, SKIP, DONE
  } dhcp_rx_state_t;

  typedef struct packed {
    logic [31:0] xid;
    logic [31:0] yiaddr;
    logic [31:0] siaddr;
    logic [7:0]  msg_type;
    logic [31:0] srv_id;
    logic [31:0] subnet_mask;
    logic [31:0] router;
    logic [31:0] dns;
    logic [31:0] lease_time;
    logic [5:0]  opt_pres;
  } dhcp_rx_fields_t;

  // Checks the BOOTP bytes with a fixed required value (op, htype, hlen and
  // the magic cookie); every other header byte is free.
  function automatic logic hdr_byte_ok(input logic [15:0] idx, input logic [7:0] b);
    logic ok;
    case (idx)
      16'd0:   ok = (b == 8'd2);
      16'd1:   ok = (b == 8'd1);
      16'd2:   ok = (b == 8'd6);
      16'd236: ok = (b == DHCP_MAGIC_COOKIE[31:24]);
      16'd237: ok = (b == DHCP_MAGIC_COOKIE[23:16]);
      16'd238: ok = (b == DHCP_MAGIC_COOKIE[15:8]);
      16'd239: ok = (b == DHCP_MAGIC_COOKIE[7:0]);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dhcp_vlg_rx_opt.sv
// TLV walker for the DHCP option area. The top FSM owns the state register;
// this block supplies the next state while in OPT_CODE/OPT_LEN/OPT_DAT and
// holds the option code, length, data count and capture register.
// Ports: clk, rst_n (async, active-low), byte_en (accepted option byte),
//        state (current parser state), dat (byte), nxt_state, commit (last
//        data byte of an option), commit_code, commit_dat (left-aligned).
module dhcp_vlg_rx_opt
  import dhcp_vlg_pkg::*;
#(
  parameter int OPT_DAT_BYTES = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           byte_en,
  input  dhcp_rx_state_t state,
  input  logic [7:0]     dat,
  output dhcp_rx_state_t nxt_state,
  output logic           commit,
  output logic [7:0]     commit_code,
  output logic [31:0]    commit_dat
);

  logic [7:0]  code_q, code_d, len_q, len_d, cnt_q, cnt_d, cnt_inc, stored;
  logic [31:0] cap_q, cap_d;

  // Short options arrive right-aligned in the shift register; move them to
  // the top so the received bytes lead the field.
  function automatic logic [31:0] left_align(input logic [31:0] v, input logic [7:0] n);
    logic [31:0] r;
    case (n)
      8'd1:    r = {v[7:0], 24'd0};
      8'd2:    r = {v[15:0], 16'd0};
      8'd3:    r = {v[23:0], 8'd0};
      default: r = v;
    endcase
    return r;
  endfunction

  always_comb begin
    code_d     = code_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    cap_d      = cap_q;
    nxt_state  = state;
    commit     = 1'b0;
    commit_dat = '0;
    cnt_inc    = cnt_q + 8'd1;
    stored     = (len_q < 8'(OPT_DAT_BYTES)) ? len_q : 8'(OPT_DAT_BYTES);
    if (byte_en) begin
      case (state)
        OPT_CODE: begin
          if (dat == DHCP_OPT_END) begin
            nxt_state = SKIP;
          end else if (dat != DHCP_OPT_PAD) begin
            code_d    = dat;
            nxt_state = OPT_LEN;
          end
        end
        OPT_LEN: begin
          len_d     = dat;
          cnt_d     = 8'd0;
          cap_d     = '0;
          nxt_state = (dat == 8'd0) ? OPT_CODE : OPT_DAT;
        end
        OPT_DAT: begin
          cnt_d = cnt_inc;
          if (cnt_q < 8'(OPT_DAT_BYTES)) cap_d = {cap_q[23:0], dat};
          if (cnt_inc == len_q) begin
            commit     = 1'b1;
            commit_dat = left_align(cap_d, stored);
            nxt_state  = OPT_CODE;
          end
        end
        default: ;
      endcase
    end
  end

  assign commit_code = code_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      cap_q  <= '0;
    end else begin
      code_q <= code_d;
      len_q  <= len_d;
      cnt_q  <= cnt_d;
      cap_q  <= cap_d;
    end
  end

endmodule

// File: rtl/dhcp_vlg_rx.sv
// DHCP receive parser. Validates the BOOTP header and magic cookie of a UDP
// payload stream, walks the option TLVs and reports the lease fields with a
// one-cycle val pulse the cycle after eof, or an err pulse on discard.
// Ports: clk, rst_n (async, active-low); strm_* payload stream; src_port,
//        dst_port, exp_xid; outputs val, err and the parsed fields.
// Optional build macro DHCP_RX_XID_CHK_EN: reject frames whose xid differs
// from exp_xid; without it exp_xid is ignored.
module dhcp_vlg_rx
  import dhcp_vlg_pkg::*;
#(
  parameter int HDR_LEN       = 240,
  parameter int OPT_MAX_LEN   = 312,
  parameter int OPT_DAT_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  strm_dat,
  input  logic        strm_val,
  input  logic        strm_sof,
  input  logic        strm_eof,
  input  logic        strm_err,
  input  logic [15:0] src_port,
  input  logic [15:0] dst_port,
  input  logic [31:0] exp_xid,
  output logic        val,
  output logic        err,
  output logic [31:0] xid,
  output logic [31:0] yiaddr,
  output logic [31:0] siaddr,
  output logic [7:0]  msg_type,
  output logic [31:0] srv_id,
  output logic [31:0] subnet_mask,
  output logic [31:0] router,
  output logic [31:0] dns,
  output logic [31:0] lease_time,
  output logic [5:0]  opt_pres
);

  localparam logic [15:0] FRAME_MAX = 16'(HDR_LEN + OPT_MAX_LEN);
  localparam logic [15:0] HDR_LAST  = 16'(HDR_LEN - 1);

  dhcp_rx_state_t  state_q, state_d, opt_nxt;
  dhcp_rx_fields_t shd_q, shd_d, out_q, out_d;
  logic [15:0] byte_cnt_q, byte_cnt_d, idx;
  logic        bad_q, bad_d, serr_q, serr_d, val_q, val_d, err_q, err_d;
  logic        in_frame, opt_en, opt_commit, trunc;
  logic [7:0]  opt_code;
  logic [31:0] opt_dat;

`ifndef DHCP_RX_XID_CHK_EN
  logic unused_exp_xid;
  assign unused_exp_xid = ^exp_xid;
`endif

  assign in_frame = state_q inside {HDR, OPT_CODE, OPT_LEN, OPT_DAT, SKIP};
  assign opt_en   = strm_val && !strm_sof && (state_q inside {OPT_CODE, OPT_LEN, OPT_DAT});

  dhcp_vlg_rx_opt #(.OPT_DAT_BYTES(OPT_DAT_BYTES)) u_opt (
    .clk         (clk),
    .rst_n       (rst_n),
    .byte_en     (opt_en),
    .state       (state_q),
    .dat         (strm_dat),
    .nxt_state   (opt_nxt),
    .commit      (opt_commit),
    .commit_code (opt_code),
    .commit_dat  (opt_dat)
  );

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    bad_d      = bad_q;
    serr_d     = serr_q;
    shd_d      = shd_q;
    out_d      = out_q;
    val_d      = 1'b0;
    err_d      = 1'b0;
    idx        = byte_cnt_q;
    trunc      = 1'b0;

    if (state_q == DONE) state_d = IDLE;

    if (strm_val && strm_sof) begin
      // A sof while a frame is open abandons that frame and restarts here.
      err_d      = in_frame;
      idx        = 16'd0;
      byte_cnt_d = 16'd1;
      bad_d      = (src_port != DHCP_SRV_PORT) || (dst_port != DHCP_CLI_PORT);
      serr_d     = strm_err;
      shd_d      = '0;
      state_d    = HDR;
      trunc      = strm_eof;
    end else if (strm_val && in_frame) begin
      if (byte_cnt_q != 16'hFFFF) byte_cnt_d = byte_cnt_q + 16'd1;
      serr_d = serr_q | strm_err;
      trunc  = strm_eof && (state_q inside {HDR, OPT_LEN, OPT_DAT});
      if (state_q inside {OPT_CODE, OPT_LEN, OPT_DAT}) state_d = opt_nxt;
    end

    if (strm_val && (strm_sof || state_q == HDR)) begin
      if (idx inside {[16'd4:16'd7]})   shd_d.xid    = {shd_q.xid[23:0], strm_dat};
      if (idx inside {[16'd16:16'd19]}) shd_d.yiaddr = {shd_q.yiaddr[23:0], strm_dat};
      if (idx inside {[16'd20:16'd23]}) shd_d.siaddr = {shd_q.siaddr[23:0], strm_dat};
`ifdef DHCP_RX_XID_CHK_EN
      if (idx == 16'd7 && {shd_q.xid[23:0], strm_dat} != exp_xid) bad_d = 1'b1;
`endif
      if (!hdr_byte_ok(idx, strm_dat)) bad_d = 1'b1;
      if (bad_d)                 state_d = SKIP;
      else if (idx == HDR_LAST)  state_d = OPT_CODE;
    end

    if (opt_commit) begin
      case (opt_code)
        DHCP_OPT_MSG_TYPE:    begin shd_d.msg_type    = opt_dat[31:24]; shd_d.opt_pres[0] = 1'b1; end
        DHCP_OPT_SRV_ID:      begin shd_d.srv_id      = opt_dat;        shd_d.opt_pres[1] = 1'b1; end
        DHCP_OPT_SUBNET_MASK: begin shd_d.subnet_mask = opt_dat;        shd_d.opt_pres[2] = 1'b1; end
        DHCP_OPT_ROUTER:      begin shd_d.router      = opt_dat;        shd_d.opt_pres[3] = 1'b1; end
        DHCP_OPT_DNS:         begin shd_d.dns         = opt_dat;        shd_d.opt_pres[4] = 1'b1; end
        DHCP_OPT_LEASE_TIME:  begin shd_d.lease_time  = opt_dat;        shd_d.opt_pres[5] = 1'b1; end
        default: ;
      endcase
    end

    // The verdict is registered on the eof byte so val/err appear in DONE,
    // one cycle after eof.
    if (strm_val && strm_eof && (strm_sof || in_frame)) begin
      if (bad_d || trunc || serr_d || !shd_d.opt_pres[0] || (byte_cnt_d > FRAME_MAX)) begin
        err_d = 1'b1;
      end else begin
        val_d = 1'b1;
        out_d = shd_d;
      end
      state_d = DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      bad_q      <= 1'b0;
      serr_q     <= 1'b0;
      shd_q      <= '0;
      out_q      <= '0;
      val_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      bad_q      <= bad_d;
      serr_q     <= serr_d;
      shd_q      <= shd_d;
      out_q      <= out_d;
      val_q      <= val_d;
      err_q      <= err_d;
    end
  end

  assign val         = val_q;
  assign err         = err_q;
  assign xid         = out_q.xid;
  assign yiaddr      = out_q.yiaddr;
  assign siaddr      = out_q.siaddr;
  assign msg_type    = out_q.msg_type;
  assign srv_id      = out_q.srv_id;
  assign subnet_mask = out_q.subnet_mask;
  assign router      = out_q.router;
  assign dns         = out_q.dns;
  assign lease_time  = out_q.lease_time;
  assign opt_pres    = out_q.opt_pres;

endmodule

// File: tb/tb_dhcp_vlg_rx.sv
`timescale 1ns/1ps
module tb_dhcp_vlg_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  strm_dat = '0;
  logic        strm_val = 1'b0, strm_sof = 1'b0, strm_eof = 1'b0, strm_err = 1'b0;
  logic [15:0] src_port = 16'd67, dst_port = 16'd68;
  logic [31:0] exp_xid = 32'h12345678;
  logic        val, err;
  logic [31:0] xid, yiaddr, siaddr, srv_id, subnet_mask, router, dns, lease_time;
  logic [7:0]  msg_type;
  logic [5:0]  opt_pres;

  always #5 clk = ~clk;

  dhcp_vlg_rx dut (
    .clk(clk), .rst_n(rst_n), .strm_dat(strm_dat), .strm_val(strm_val),
    .strm_sof(strm_sof), .strm_eof(strm_eof), .strm_err(strm_err),
    .src_port(src_port), .dst_port(dst_port), .exp_xid(exp_xid),
    .val(val), .err(err), .xid(xid), .yiaddr(yiaddr), .siaddr(siaddr),
    .msg_type(msg_type), .srv_id(srv_id), .subnet_mask(subnet_mask),
    .router(router), .dns(dns), .lease_time(lease_time), .opt_pres(opt_pres)
  );

  logic [269:0] dut_f;
  assign dut_f = {xid, yiaddr, siaddr, msg_type, srv_id, subnet_mask, router, dns, lease_time, opt_pres};

  int n_chk = 0, n_err = 0;
  logic exp_val = 1'b0, exp_err = 1'b0, pend_val = 1'b0, pend_err = 1'b0, pend_upd = 1'b0;
  logic [269:0] exp_f = '0, pend_f = '0;
  logic [7:0] frm[$];
  bit in_frame = 0;

  // Per-cycle comparison against the model expectations.
  always @(negedge clk) begin
    n_chk++;
    if (val !== exp_val) begin n_err++; $display("FAIL val t=%0t got %0b want %0b", $time, val, exp_val); end
    n_chk++;
    if (err !== exp_err) begin n_err++; $display("FAIL err t=%0t got %0b want %0b", $time, err, exp_err); end
    n_chk++;
    if (dut_f !== exp_f) begin n_err++; $display("FAIL fields t=%0t got %h want %h", $time, dut_f, exp_f); end
  end

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin n_err++; $display("FAIL %s got %h want %h", nm, act, want); end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    exp_val = pend_val; exp_err = pend_err;
    if (pend_upd) exp_f = pend_f;
    pend_val = 1'b0; pend_err = 1'b0; pend_upd = 1'b0;
  endtask

  // Whole-frame reference parse: decides accept/discard and the fields.
  function automatic void model(input bit serr, output bit ok, output logic [269:0] fo);
    int n = frm.size();
    bit bad = 0;
    int i, ln;
    logic [31:0] x = 0, yi = 0, si = 0, sid = 0, msk = 0, rt = 0, dn = 0, ls = 0, d;
    logic [7:0] mt = 0;
    logic [5:0] pr = 0;
    if (src_port != 16'd67 || dst_port != 16'd68) bad = 1;
    if (n <= 240) bad = 1;
    else begin
      if (frm[0] != 8'd2 || frm[1] != 8'd1 || frm[2] != 8'd6) bad = 1;
      if ({frm[236], frm[237], frm[238], frm[239]} != 32'h63825363) bad = 1;
      x  = {frm[4], frm[5], frm[6], frm[7]};
      yi = {frm[16], frm[17], frm[18], frm[19]};
      si = {frm[20], frm[21], frm[22], frm[23]};
`ifdef DHCP_RX_XID_CHK_EN
      if (x != exp_xid) bad = 1;
`endif
    end
    i = 240;
    while (!bad && i < n) begin
      if (frm[i] == 8'd0) i++;
      else if (frm[i] == 8'd255) break;
      else if (i == n - 1) break;
      else begin
        ln = int'(frm[i+1]);
        if (i + 1 + ln >= n - 1) begin bad = 1; break; end
        d = 0;
        for (int k = 0; k < ((ln < 4) ? ln : 4); k++) d[31-8*k -: 8] = frm[i+2+k];
        case (frm[i])
          8'd53: begin mt  = d[31:24]; pr[0] = 1; end
          8'd54: begin sid = d; pr[1] = 1; end
          8'd1:  begin msk = d; pr[2] = 1; end
          8'd3:  begin rt  = d; pr[3] = 1; end
          8'd6:  begin dn  = d; pr[4] = 1; end
          8'd51: begin ls  = d; pr[5] = 1; end
          default: ;
        endcase
        i += 2 + ln;
      end
    end
    ok = !bad && !serr && pr[0] && (n <= 552);
    fo = {x, yi, si, mt, sid, msk, rt, dn, ls, pr};
  endfunction

  task automatic hdr(input logic [31:0] x, input logic [31:0] yi, input logic [31:0] si);
    logic [31:0] ck = 32'h63825363;
    frm.delete();
    for (int i = 0; i < 240; i++) frm.push_back(8'h00);
    frm[0] = 8'd2; frm[1] = 8'd1; frm[2] = 8'd6;
    for (int k = 0; k < 4; k++) begin
      frm[4+k]   = x[31-8*k -: 8];
      frm[16+k]  = yi[31-8*k -: 8];
      frm[20+k]  = si[31-8*k -: 8];
      frm[236+k] = ck[31-8*k -: 8];
    end
  endtask

  task automatic b(input logic [7:0] v);
    frm.push_back(v);
  endtask

  task automatic opt(input logic [7:0] c, input int ln, input logic [63:0] d);
    frm.push_back(c);
    frm.push_back(8'(ln));
    for (int k = 0; k < ln; k++) frm.push_back(d[63-8*k -: 8]);
  endtask

  task automatic offer_opts();
    opt(8'd53, 1, {8'd2, 56'd0});
    opt(8'd54, 4, {32'hC0A80101, 32'd0});
    opt(8'd51, 4, {32'h00015180, 32'd0});
    opt(8'd1,  4, {32'hFFFFFF00, 32'd0});
    b(8'd255);
  endtask

  task automatic idle_inputs();
    strm_val = 1'b0; strm_sof = 1'b0; strm_eof = 1'b0; strm_err = 1'b0; strm_dat = 8'h00;
  endtask

  // stop_at >= 0 leaves the frame open after that byte.
  task automatic send(input int stop_at, input int err_at, input bit gaps);
    int n = frm.size();
    bit ok;
    logic [269:0] mf;
    model(err_at >= 0 && err_at < n, ok, mf);
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 37 == 5)) begin
        strm_val = 1'b0; strm_sof = 1'b1; strm_eof = 1'b1; strm_err = 1'b1; strm_dat = 8'hFF;
        tick(); tick();
      end
      strm_val = 1'b1; strm_dat = frm[i];
      strm_sof = (i == 0); strm_eof = (i == n - 1); strm_err = (i == err_at);
      if (i == 0) begin
        if (in_frame) pend_err = 1'b1;
        in_frame = 1;
      end
      if (i == n - 1) begin
        in_frame = 0;
        pend_val = ok; pend_err = pend_err | !ok; pend_upd = ok; pend_f = mf;
      end
      tick();
      if (i == stop_at) begin idle_inputs(); return; end
    end
    idle_inputs();
    tick(); tick();
  endtask

  initial begin
    #1 rst_n = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b1;
    lit("rst_opt_pres", {26'd0, opt_pres}, 32'd0);
    lit("rst_xid", xid, 32'd0);

    // OFFER
    hdr(32'h12345678, 32'hC0A80132, 32'hC0A80101);
    offer_opts();
    send(-1, -1, 0);
    lit("offer_msg_type", {24'd0, msg_type}, 32'd2);
    lit("offer_lease", lease_time, 32'h00015180);
    lit("offer_opt_pres", {26'd0, opt_pres}, 32'h27);
    lit("offer_yiaddr", yiaddr, 32'hC0A80132);
    lit("offer_mask", subnet_mask, 32'hFFFFFF00);
    lit("offer_srv_id", srv_id, 32'hC0A80101);

    // Bad cookie: discarded, outputs hold
    hdr(32'h12345678, 32'hC0A80199, 32'hC0A80101);
    frm[239] = 8'h64;
    offer_opts();
    send(-1, -1, 0);
    lit("badck_yiaddr_hold", yiaddr, 32'hC0A80132);

    // Pads, unknown option 12, 8-byte router, short dns, input stalls
    hdr(32'hAABBCCDD, 32'h0A000064, 32'h00000000);
    b(8'd0); b(8'd0);
    opt(8'd53, 1, {8'd5, 56'd0});
    b(8'd0);
    opt(8'd12, 8, 64'h686F73746E616D65);
    opt(8'd3, 8, 64'h0A0000010A000002);
    b(8'd0);
    opt(8'd6, 2, {16'h0808, 48'd0});
    opt(8'd54, 4, {32'h0A000001, 32'd0});
    b(8'd255); b(8'd0); b(8'd0);
    send(-1, -1, 1);
    lit("pad_router", router, 32'h0A000001);
    lit("pad_dns", dns, 32'h08080000);
    lit("pad_opt_pres", {26'd0, opt_pres}, 32'h1B);
    lit("pad_msg_type", {24'd0, msg_type}, 32'd5);

    // eof inside option 54 data
    hdr(32'h1, 32'h2, 32'h3);
    opt(8'd53, 1, {8'd2, 56'd0});
    b(8'd54); b(8'd4); b(8'hC0); b(8'hA8);
    send(-1, -1, 0);

    // Missing option 53
    hdr(32'h1, 32'h2, 32'h3);
    opt(8'd54, 4, {32'hC0A80101, 32'd0});
    b(8'd255);
    send(-1, -1, 0);

    // Upstream error flagged mid-frame
    hdr(32'h12345678, 32'hC0A80133, 32'h0);
    offer_opts();
    send(-1, 30, 0);

    // Wrong source port
    src_port = 16'd68;
    hdr(32'h12345678, 32'hC0A80134, 32'h0);
    offer_opts();
    send(-1, -1, 0);
    src_port = 16'd67;

    // Option area exactly at the limit, then one byte over
    hdr(32'h55, 32'h0A0A0A0A, 32'h0);
    opt(8'd53, 1, {8'd2, 56'd0});
    while (frm.size() < 552) b(8'd0);
    send(-1, -1, 0);
    lit("maxlen_yiaddr", yiaddr, 32'h0A0A0A0A);
    hdr(32'h56, 32'h0B0B0B0B, 32'h0);
    opt(8'd53, 1, {8'd2, 56'd0});
    while (frm.size() < 553) b(8'd0);
    send(-1, -1, 0);

    // New sof while a frame is open
    hdr(32'h99, 32'h01010101, 32'h0);
    offer_opts();
    send(50, -1, 0);
    tick();
    hdr(32'h12345678, 32'hC0A80140, 32'h0);
    offer_opts();
    send(-1, -1, 0);
    lit("abort_yiaddr", yiaddr, 32'hC0A80140);

    // Asynchronous reset at byte 100
    hdr(32'h12345678, 32'hC0A80150, 32'h0);
    offer_opts();
    send(100, -1, 0);
    #2 rst_n = 1'b0;
    exp_val = 1'b0; exp_err = 1'b0; exp_f = '0;
    pend_val = 1'b0; pend_err = 1'b0; pend_upd = 1'b0; in_frame = 0;
    #1;
    lit("rst_mid_yiaddr", yiaddr, 32'd0);
    lit("rst_mid_opt_pres", {26'd0, opt_pres}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
    hdr(32'hCAFE0001, 32'hC0A80160, 32'hC0A80101);
    opt(8'd53, 1, {8'd5, 56'd0});
    opt(8'd51, 4, {32'h00000E10, 32'd0});
    b(8'd255);
    send(-1, -1, 0);
    lit("ack_msg_type", {24'd0, msg_type}, 32'd5);
    lit("ack_lease", lease_time, 32'h00000E10);

    // xid differing from the outstanding request
    exp_xid = 32'h12345678;
    hdr(32'h87654321, 32'hC0A80170, 32'h0);
    offer_opts();
    send(-1, -1, 0);
`ifdef DHCP_RX_XID_CHK_EN
    lit("xid_hold", xid, 32'hCAFE0001);
`else
    lit("xid_accept", xid, 32'h87654321);
`endif

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
